// File: rtl/detector_ctrl.sv
// rtl/detector_ctrl.sv - frame scheduler, latency tracker and result FIFO for the sphere detector
// Credits bound in-flight plus buffered results to FIFO_DEPTH, so the stall-free detector never overflows.
module detector_ctrl #(
  parameter int WL         = 16,
  parameter int LATENCY    = 26,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_Y      = 16,
  localparam int NYW       = $clog2(MAX_Y + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_r_valid,
  output logic             in_r_ready,
  input  logic [36*WL-1:0] in_r,
  input  logic [NYW-1:0]   in_num_y,
  input  logic             in_y_valid,
  output logic             in_y_ready,
  input  logic [8*WL-1:0]  in_y,
  output logic [36*WL-1:0] det_rmat,
  output logic [8*WL-1:0]  det_yarr,
  input  logic [15:0]      det_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_x,
  output logic             out_last,
  output logic             busy
);

  localparam logic IDLE   = 1'b0;
  localparam logic STREAM = 1'b1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = IW + 1;

  logic               state;
  logic [36*WL-1:0]   r_reg;
  logic [NYW-1:0]     y_cnt;
  logic [LATENCY-1:0] v_pipe;
  logic [LATENCY-1:0] l_pipe;
  logic [IW-1:0]      inflight;
  logic [16:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]      wptr, rptr, occ;
  logic [CW-1:0]      used;
  logic [16:0]        head;
  logic               full, empty, issue, push, pop, y_last;

  assign occ   = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign used  = CW'(inflight) + CW'(occ);

  assign in_r_ready = (state == IDLE);
  assign in_y_ready = (state == STREAM) && (used < CW'(FIFO_DEPTH));
  assign issue      = in_y_valid && in_y_ready;
  assign y_last     = (y_cnt == NYW'(1));
  assign push       = v_pipe[LATENCY-1];
  assign pop        = !empty && out_ready;

  assign det_rmat = r_reg;
  assign det_yarr = issue ? in_y : '0;

  assign head      = mem[rptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_x     = empty ? 16'd0 : head[15:0];
  assign out_last  = !empty && head[16];
  assign busy      = (state != IDLE) || (inflight != '0) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r_reg <= '0;
      y_cnt <= '0;
    end else if (state == IDLE) begin
      if (in_r_valid) begin
        r_reg <= in_r;
        if (in_num_y != '0) begin
          y_cnt <= in_num_y;
          state <= STREAM;
        end
      end
    end else if (issue) begin
      y_cnt <= y_cnt - NYW'(1);
      if (y_last) state <= IDLE;
    end
  end

  // Valid/last ride alongside the detector pipeline; clearing them orphans results of dropped vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[LATENCY-2:0], issue};
      l_pipe <= {l_pipe[LATENCY-2:0], issue && y_last};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue && !push) begin
      inflight <= inflight + IW'(1);
    end else if (push && !issue) begin
      inflight <= inflight - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {l_pipe[LATENCY-1], det_x};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_credit_inv:  assert property (@(posedge clk) disable iff (rst) used <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_detector_ctrl.sv
// tb/tb_detector_ctrl.sv - randomized self-checking bench for detector_ctrl with a stand-in detector
// Expected results are computed from the stimulus and compared in issue order at the FIFO output.
module tb_detector_ctrl;
  localparam int WL = 16, LAT = 26, DEPTH = 32, MAXY = 16;
  localparam int NYW = $clog2(MAXY + 1);
  localparam int RW = 36 * WL, YW = 8 * WL;

  logic clk = 1'b0, rst = 1'b1;
  logic in_r_valid, in_r_ready, in_y_valid, in_y_ready;
  logic [RW-1:0] in_r, det_rmat;
  logic [NYW-1:0] in_num_y;
  logic [YW-1:0] in_y, det_yarr;
  logic [15:0] det_x, out_x;
  logic out_valid, out_ready, out_last, busy;

  detector_ctrl #(.WL(WL), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .MAX_Y(MAXY)) dut (
    .clk(clk), .rst(rst),
    .in_r_valid(in_r_valid), .in_r_ready(in_r_ready), .in_r(in_r), .in_num_y(in_num_y),
    .in_y_valid(in_y_valid), .in_y_ready(in_y_ready), .in_y(in_y),
    .det_rmat(det_rmat), .det_yarr(det_yarr), .det_x(det_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int issued = 0, out_cnt = 0, last_cnt = 0, r_acc = 0, yr_cycles = 0;
  int first_issue_cyc = -1, last_issue_cyc = -1, first_out_cyc = -1, first_pop_cyc = -1;
  int y_pct = 100, ord_pct = 100, d_state = 0, rem = 0;
  bit abort = 1'b0, just_done = 1'b0, y_taken = 1'b0, r_taken = 1'b0;
  logic [RW-1:0] cur_r;
  logic [16:0] exp_q[$];
  int frame_q[$];
  logic [15:0] dpipe [LAT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] fx(input logic [YW-1:0] y, input logic [RW-1:0] r);
    logic [15:0] a;
    a = 16'h1d0f;
    for (int i = 0; i < 8; i++) a = {a[14:0], a[15]} ^ y[i*16 +: 16];
    for (int i = 0; i < 36; i++) a = {a[13:0], a[15:14]} ^ r[i*16 +: 16];
    return a;
  endfunction

  function automatic logic [RW-1:0] rand_r();
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [YW-1:0] rand_y();
    logic [YW-1:0] v;
    for (int i = 0; i < YW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Stand-in detector: a fixed-latency function of whatever is on its inputs each cycle.
  always @(posedge clk) begin
    dpipe[0] <= fx(det_yarr, det_rmat);
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign det_x = dpipe[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(1, 100) <= ord_pct);
    end
  end

  // Frame driver: inputs change 1 after the edge, handshakes are sampled on the falling edge.
  initial begin
    in_r_valid = 1'b0; in_y_valid = 1'b0; in_r = '0; in_y = '0; in_num_y = '0;
    forever begin
      @(posedge clk); #1;
      if (y_taken) begin in_y_valid = 1'b0; y_taken = 1'b0; end
      if (r_taken) begin in_r_valid = 1'b0; r_taken = 1'b0; end
      if (abort) begin
        d_state = 0; in_r_valid = 1'b0; in_y_valid = 1'b0; just_done = 1'b0;
      end else begin
        if (d_state == 0 && frame_q.size() > 0) begin
          in_num_y = NYW'(frame_q.pop_front());
          in_r = rand_r();
          in_r_valid = 1'b1;
          d_state = 1;
        end else if (d_state == 0) begin
          just_done = 1'b0;
        end
        if (d_state == 2 && !in_y_valid && $urandom_range(1, 100) <= y_pct) begin
          in_y = rand_y();
          in_y_valid = 1'b1;
        end
      end
      @(negedge clk);
      if (d_state == 1) begin
        if (just_done) begin chk("b2b_r_ready", in_r_ready, 1); just_done = 1'b0; end
        chk("idle_y_ready", in_y_ready, 0);
        if (in_r_ready) begin
          r_acc++; r_taken = 1'b1; cur_r = in_r;
          if (in_num_y == '0) d_state = 0;
          else begin rem = int'(in_num_y); d_state = 2; end
        end
      end else if (d_state == 2 && in_y_valid && in_y_ready) begin
        exp_q.push_back({rem == 1, fx(in_y, cur_r)});
        issued++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        y_taken = 1'b1;
        rem--;
        if (rem == 0) begin d_state = 0; just_done = 1'b1; end
        chk("credit_inv", exp_q.size() <= DEPTH, 1);
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (in_y_ready) yr_cycles++;
    if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
    if (out_valid && out_ready) begin
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_x", out_x, e[15:0]);
        chk("out_last", out_last, e[16]);
      end
      out_cnt++;
      if (out_last) last_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    bit ok = 1'b0;
    while (n < bound) begin
      if (frame_q.size() == 0 && d_state == 0 && exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      step(1);
      n++;
    end
    chk("drain_done", ok, 1);
  endtask

  initial begin
    int i0, o0, l0, r0, sum, n;
    bit seen;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("rst_in_r_ready", in_r_ready, 1);
    chk("rst_in_y_ready", in_y_ready, 0);
    chk("rst_det_rmat", det_rmat == '0, 1);
    chk("rst_det_yarr", det_yarr == '0, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);

    // one frame of four, full throughput
    y_pct = 100; ord_pct = 100;
    first_issue_cyc = -1; first_out_cyc = -1; yr_cycles = 0;
    o0 = out_cnt; l0 = last_cnt;
    frame_q.push_back(4);
    wait_idle(200);
    chk("t1_y_ready_cycles", yr_cycles, 4);
    chk("t1_out_count", out_cnt - o0, 4);
    chk("t1_last_count", last_cnt - l0, 1);
    chk("t1_latency", first_out_cyc - first_issue_cyc, LAT + 1);

    // empty frame
    r0 = r_acc; o0 = out_cnt; yr_cycles = 0;
    frame_q.push_back(0);
    n = 0;
    while (r_acc == r0 && n < 20) begin step(1); n++; end
    chk("t2_r_accepted", r_acc - r0, 1);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("t2_busy", busy, 0);
    end
    chk("t2_y_ready_cycles", yr_cycles, 0);
    chk("t2_out_count", out_cnt - o0, 0);

    // back-pressure: credits stop issue at FIFO_DEPTH outstanding
    ord_pct = 0;
    step(2);
    i0 = issued;
    frame_q.push_back(16); frame_q.push_back(16); frame_q.push_back(4);
    step(130);
    chk("t3_issued", issued - i0, 32);
    chk("t3_y_ready", in_y_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_busy", busy, 1);
    first_pop_cyc = -1;
    ord_pct = 100;
    n = 0;
    while (issued - i0 < 33 && n < 50) begin step(1); n++; end
    chk("t3_resumed", issued - i0 >= 33, 1);
    chk("t3_resume_delay", last_issue_cyc - first_pop_cyc, 1);
    wait_idle(300);

    // random gaps over 100 frames
    y_pct = 60; ord_pct = 50;
    o0 = out_cnt; l0 = last_cnt; sum = 0;
    for (int f = 0; f < 100; f++) begin
      n = $urandom_range(1, 16);
      sum += n;
      frame_q.push_back(n);
    end
    wait_idle(30000);
    chk("t4_last_count", last_cnt - l0, 100);
    chk("t4_out_count", out_cnt - o0, sum);

    // reset with vectors in flight
    y_pct = 100; ord_pct = 100;
    i0 = issued;
    frame_q.push_back(16);
    n = 0;
    while (issued - i0 < 10 && n < 100) begin step(1); n++; end
    chk("t5_ten_issued", issued - i0 >= 10, 1);
    abort = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    chk("t5_r_ready", in_r_ready, 1);
    chk("t5_busy", busy, 0);
    seen = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      if (out_valid) seen = 1'b1;
      step(1);
    end
    chk("t5_no_out_valid", seen, 0);
    abort = 1'b0;

    // recovery traffic after reset
    o0 = out_cnt; l0 = last_cnt;
    frame_q.push_back(2); frame_q.push_back(0); frame_q.push_back(5);
    wait_idle(300);
    chk("t6_out_count", out_cnt - o0, 7);
    chk("t6_last_count", last_cnt - l0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
